adc_sample_app_ui_mc: RTL
=========================

Name: adc_sample_app_ui_mc

Overview:
Multi-channel successor of the ADC sample application register file. Decodes the app_axi single-cycle read/write request interface into a global register bank plus NUM_CH identical per-channel banks. Each bank drives the channel's sample and move control, reads back its status, and records addresses. New relative to the single-channel block:
- channel-enable gating of control pulses
- sticky W1C event flags built from rising-edge detection
- a maskable, registered interrupt output

Parameters:
NUM_CH, 4, number of ADC channels (1..8)
MM_ADDR_WIDTH, 32, width of the memory-mapped address inputs (<= S_AXI_DATA_WIDTH)
S_AXI_DATA_WIDTH, 32, register data width
S_AXI_ADDR_WIDTH, 16, register byte-address width
CH_BASE, 16'h0100, byte address of channel 0 bank
CH_STRIDE, 16'h0020, byte distance between channel banks
IP_ID, 32'h41444301, constant returned by the ID register

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
app_axi_rreq  in  1  one-cycle read request
app_axi_rack  out  1  read acknowledge pulse
app_axi_raddr  in  S_AXI_ADDR_WIDTH  read byte address
app_axi_rdata  out  S_AXI_DATA_WIDTH  read data
app_axi_wreq  in  1  one-cycle write request
app_axi_wack  out  1  write acknowledge pulse
app_axi_waddr  in  S_AXI_ADDR_WIDTH  write byte address
app_axi_wdata  in  S_AXI_DATA_WIDTH  write data
sample_start / sample_trig / update_config  out  NUM_CH  per-channel one-cycle control pulses
sample_busy / sample_done / sample_err  in  NUM_CH  per-channel sampler status
move_en  out  NUM_CH  per-channel mover enable level
move_busy / move_done / move_err  in  NUM_CH  per-channel mover status
move_addr, rec_trig_addr, rec_start_addr, rec_end_addr  in  NUM_CH*MM_ADDR_WIDTH  per-channel addresses; channel c occupies bits [c*MM_ADDR_WIDTH +: MM_ADDR_WIDTH]
irq  out  1  level interrupt

Behaviour:
- Reset: rack, wack, irq = 0; rdata = 0; all control pulses = 0; move_en = 0; CH_EN = 0; IRQ_MASK = 0; all sticky bits = 0; edge-detect history = 0.
- Addressing: bits [1:0] are ignored. Global registers:
  - 0x00 ID (RO)
  - 0x04 CH_EN[NUM_CH-1:0] (RW)
  - 0x08 IRQ_STATUS (RO): bit c = OR of channel c sticky bits
  - 0x0C IRQ_MASK[NUM_CH-1:0] (RW)
- Channel bank, base = CH_BASE + c*CH_STRIDE:
  - +0x00 CTRL, write-only pulse bits: bit0 start, bit1 trig, bit2 update_config. bit3 move_en is RW and reads back; read returns {28'b0, move_en, 3'b0}.
  - +0x04 STATUS (RO): {move_err, move_done, move_busy, sample_err, sample_done, sample_busy} in bits [5:0].
  - +0x08 STICKY (W1C): bit0 sample_done rise, bit1 sample_err rise, bit2 move_done rise, bit3 move_err rise.
  - +0x0C move_addr, +0x10 rec_trig_addr, +0x14 rec_start_addr, +0x18 rec_end_addr (RO). Zero-extended to S_AXI_DATA_WIDTH and sampled at the request cycle.
- Unmapped addresses, and channels >= NUM_CH: reads return 0, writes are ignored, and both are still acknowledged.
- Read timing: rreq high in cycle N -> rdata valid and rack = 1 in cycle N+1 for exactly one cycle. rdata holds until the next read.
- Write timing: wreq high in cycle N -> register updated and wack = 1 in cycle N+1. Control pulses are asserted in cycle N+1 for exactly one cycle.
- Reads and writes are independent: simultaneous rreq/wreq are both serviced in the same cycle. A read of a register written the same cycle returns the old value.
- CH_EN gating:
  - A start/trig/update_config write to a channel with CH_EN[c] = 0 produces no pulse.
  - Clearing CH_EN[c] forces move_en[c] = 0 on the next cycle, and move_en[c] cannot be set while CH_EN[c] = 0.
- Sticky flags: set on a 0->1 transition of the registered input history. Because history resets to 0, an input already high when reset releases sets its flag in the first cycle.
- Sticky W1C: writing 1 clears the bit. If a set event and a W1C land in the same cycle, set wins.
- irq = registered |(IRQ_STATUS & IRQ_MASK), i.e. one cycle after the sticky bit changes.
- Reset asserted mid-transaction: the transaction is aborted, no ack is issued, and all state returns to reset values.

Test Plan:
- Write 0x04 = 0x0000000F, read 0x04 -> rack one cycle after rreq, rdata = 0x0000000F. Read 0x00 -> 0x41444301.
- CH_EN = 0x1; write 0x0100 = 0x7 -> sample_start, sample_trig, update_config[0] each pulse for one cycle. Write 0x0120 = 0x1 -> sample_start[1] stays 0.
- Hold sample_done[2] = 1 from reset release; IRQ_MASK = 0x4 -> read 0x0148 = 0x1 and irq = 1. Write 0x0148 = 0x1 -> STICKY reads 0 and irq drops. Holding the input high does not re-set the flag.
- Assert sample_err[0] rise in the same cycle as a W1C of bit1 -> bit1 remains 1.
- rec_end_addr[3] = 0xC0007FFF; read 0x0178 -> 0xC0007FFF. Read 0x0200 with NUM_CH = 4 -> 0, rack still pulses.
- Set move_en[0] via 0x0100 = 0x8, then write CH_EN = 0 -> move_en[0] = 0 next cycle. Assert rst mid-write -> wack never pulses and all outputs return to 0.

Source files
------------

// File: rtl/adc_sample_app_ui_mc.sv
// adc_sample_app_ui_mc: multi-channel ADC register file with channel gating,
// sticky W1C event flags and a maskable, registered interrupt.
module adc_sample_app_ui_mc #(
    parameter int                          NUM_CH           = 4,
    parameter int                          MM_ADDR_WIDTH    = 32,
    parameter int                          S_AXI_DATA_WIDTH = 32,
    parameter int                          S_AXI_ADDR_WIDTH = 16,
    parameter logic [S_AXI_ADDR_WIDTH-1:0] CH_BASE          = 16'h0100,
    parameter logic [S_AXI_ADDR_WIDTH-1:0] CH_STRIDE        = 16'h0020,
    parameter logic [31:0]                 IP_ID            = 32'h41444301
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            app_axi_rreq,
    output logic                            app_axi_rack,
    input  logic [S_AXI_ADDR_WIDTH-1:0]     app_axi_raddr,
    output logic [S_AXI_DATA_WIDTH-1:0]     app_axi_rdata,
    input  logic                            app_axi_wreq,
    output logic                            app_axi_wack,
    input  logic [S_AXI_ADDR_WIDTH-1:0]     app_axi_waddr,
    input  logic [S_AXI_DATA_WIDTH-1:0]     app_axi_wdata,
    output logic [NUM_CH-1:0]               sample_start,
    output logic [NUM_CH-1:0]               sample_trig,
    output logic [NUM_CH-1:0]               update_config,
    input  logic [NUM_CH-1:0]               sample_busy,
    input  logic [NUM_CH-1:0]               sample_done,
    input  logic [NUM_CH-1:0]               sample_err,
    output logic [NUM_CH-1:0]               move_en,
    input  logic [NUM_CH-1:0]               move_busy,
    input  logic [NUM_CH-1:0]               move_done,
    input  logic [NUM_CH-1:0]               move_err,
    input  logic [NUM_CH*MM_ADDR_WIDTH-1:0] move_addr,
    input  logic [NUM_CH*MM_ADDR_WIDTH-1:0] rec_trig_addr,
    input  logic [NUM_CH*MM_ADDR_WIDTH-1:0] rec_start_addr,
    input  logic [NUM_CH*MM_ADDR_WIDTH-1:0] rec_end_addr,
    output logic                            irq
);
    localparam int AW = S_AXI_ADDR_WIDTH;
    localparam int DW = S_AXI_DATA_WIDTH;
    localparam int MW = MM_ADDR_WIDTH;

    function automatic logic [AW-1:0] reg_addr(input int c, input logic [AW-1:0] off);
        return CH_BASE + AW'(c) * CH_STRIDE + off;
    endfunction

    logic                   rack_q, wack_q, irq_q;
    logic [DW-1:0]          rdata_q, rd;
    logic [AW-1:0]          ra, wa;
    logic [3:0]             wlo;
    logic [NUM_CH-1:0]      ch_en_q, ch_en_d, irq_mask_q, irq_mask_d;
    logic [NUM_CH-1:0]      start_q, start_d, trig_q, trig_d, upd_q, upd_d;
    logic [NUM_CH-1:0]      move_en_q, move_en_d, move_set, irq_status;
    logic [NUM_CH-1:0][3:0] sticky_q, sticky_d, hist_q, ev, w1c;

    // Read decode; bits [1:0] of the address are don't-care.
    always_comb begin
        ra = app_axi_raddr & ~AW'(3);
        irq_status = '0;
        for (int c = 0; c < NUM_CH; c++) irq_status[c] = |sticky_q[c];
        rd = '0;
        if (ra == AW'('h00)) rd = DW'(IP_ID);
        if (ra == AW'('h04)) rd = DW'(ch_en_q);
        if (ra == AW'('h08)) rd = DW'(irq_status);
        if (ra == AW'('h0C)) rd = DW'(irq_mask_q);
        for (int c = 0; c < NUM_CH; c++) begin
            if (ra == reg_addr(c, AW'('h00))) rd = DW'({move_en_q[c], 3'b000});
            if (ra == reg_addr(c, AW'('h04))) rd = DW'({move_err[c], move_done[c], move_busy[c],
                                                          sample_err[c], sample_done[c], sample_busy[c]});
            if (ra == reg_addr(c, AW'('h08))) rd = DW'(sticky_q[c]);
            if (ra == reg_addr(c, AW'('h0C))) rd = DW'(move_addr[c*MW +: MW]);
            if (ra == reg_addr(c, AW'('h10))) rd = DW'(rec_trig_addr[c*MW +: MW]);
            if (ra == reg_addr(c, AW'('h14))) rd = DW'(rec_start_addr[c*MW +: MW]);
            if (ra == reg_addr(c, AW'('h18))) rd = DW'(rec_end_addr[c*MW +: MW]);
        end
    end

    // Write decode; pulses use the current CH_EN, move_en follows the next CH_EN.
    always_comb begin
        wa = app_axi_waddr & ~AW'(3);
        wlo = 4'(app_axi_wdata);
        ch_en_d = ch_en_q;
        irq_mask_d = irq_mask_q;
        start_d = '0;
        trig_d = '0;
        upd_d = '0;
        move_set = move_en_q;
        w1c = '0;
        if (app_axi_wreq) begin
            if (wa == AW'('h04)) ch_en_d = NUM_CH'(app_axi_wdata);
            if (wa == AW'('h0C)) irq_mask_d = NUM_CH'(app_axi_wdata);
            for (int c = 0; c < NUM_CH; c++) begin
                if (wa == reg_addr(c, AW'('h00))) begin
                    start_d[c] = wlo[0] & ch_en_q[c];
                    trig_d[c] = wlo[1] & ch_en_q[c];
                    upd_d[c] = wlo[2] & ch_en_q[c];
                    move_set[c] = wlo[3];
                end
                if (wa == reg_addr(c, AW'('h08))) w1c[c] = wlo;
            end
        end
        move_en_d = move_set & ch_en_d;
    end

    // Sticky events: a rising edge sets the flag and wins over a same-cycle W1C.
    always_comb begin
        ev = '0;
        sticky_d = sticky_q;
        for (int c = 0; c < NUM_CH; c++) begin
            ev[c] = {move_err[c], move_done[c], sample_err[c], sample_done[c]};
            sticky_d[c] = (sticky_q[c] & ~w1c[c]) | (ev[c] & ~hist_q[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rack_q     <= 1'b0;
            wack_q     <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            ch_en_q    <= '0;
            irq_mask_q <= '0;
            start_q    <= '0;
            trig_q     <= '0;
            upd_q      <= '0;
            move_en_q  <= '0;
            sticky_q   <= '0;
            hist_q     <= '0;
        end else begin
            rack_q     <= app_axi_rreq;
            wack_q     <= app_axi_wreq;
            irq_q      <= |(irq_status & irq_mask_q);
            rdata_q    <= app_axi_rreq ? rd : rdata_q;
            ch_en_q    <= ch_en_d;
            irq_mask_q <= irq_mask_d;
            start_q    <= start_d;
            trig_q     <= trig_d;
            upd_q      <= upd_d;
            move_en_q  <= move_en_d;
            sticky_q   <= sticky_d;
            hist_q     <= ev;
        end
    end

    assign app_axi_rack  = rack_q;
    assign app_axi_rdata = rdata_q;
    assign app_axi_wack  = wack_q;
    assign sample_start  = start_q;
    assign sample_trig   = trig_q;
    assign update_config = upd_q;
    assign move_en       = move_en_q;
    assign irq           = irq_q;
endmodule
